// File: rtl/common_defs_pkg.sv
// Shared definitions for the ray pipeline: fixed-point type, screen geometry
// and the scheduler state encoding that control-register readback also uses.
`ifndef SCREEN_WIDTH
`define SCREEN_WIDTH 640
`endif
`ifndef SCREEN_HEIGHT
`define SCREEN_HEIGHT 480
`endif

package common_defs;

  typedef logic signed [31:0] fp;

  localparam int FRAC_BITS          = 16;
  localparam int DEF_SCREEN_WIDTH   = `SCREEN_WIDTH;
  localparam int DEF_SCREEN_HEIGHT  = `SCREEN_HEIGHT;
  localparam int DEF_MAX_INFLIGHT   = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } sched_state_e;

endpackage

// File: rtl/ray_pixel_scheduler_credit_counter.sv
// Up/down counter of rays in flight; an unmatched decrement at zero is
// refused and flagged on underflow for the cycle it is presented.
module ray_credit_counter #(
  parameter int MAX = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         inc,
  input  logic                         dec,
  output logic [$clog2(MAX+1)-1:0]     count,
  output logic                         full,
  output logic                         empty,
  output logic                         underflow
);

  localparam int CW = $clog2(MAX + 1);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d   = count_q;
    underflow = 1'b0;
    if (inc && !dec) begin
      if (count_q != CW'(MAX)) count_d = count_q + CW'(1);
    end else if (dec && !inc) begin
      if (count_q == '0) underflow = 1'b1;
      else               count_d   = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign count = count_q;
  assign full  = (count_q == CW'(MAX));
  assign empty = (count_q == '0);

endmodule

// File: rtl/ray_pixel_scheduler.sv
// Raster-scan front end for ray_generator: issues one pixel per cycle while
// credits allow, and runs the frame start/abort/drain/done handshake.
module ray_pixel_scheduler
  import common_defs::*;
#(
  parameter int SCREEN_WIDTH  = DEF_SCREEN_WIDTH,
  parameter int SCREEN_HEIGHT = DEF_SCREEN_HEIGHT,
  parameter int MAX_INFLIGHT  = DEF_MAX_INFLIGHT
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic                              abort,
  input  logic                              ray_retire,
  output fp                                 screen_x,
  output fp                                 screen_y,
  output logic                              coords_valid,
  output logic                              sof,
  output logic                              eol,
  output logic                              eof,
  output logic                              busy,
  output logic                              frame_done,
  output logic [$clog2(MAX_INFLIGHT+1)-1:0] inflight,
  output logic                              credit_err
);

  localparam int X_W = (SCREEN_WIDTH  > 1) ? $clog2(SCREEN_WIDTH)  : 1;
  localparam int Y_W = (SCREEN_HEIGHT > 1) ? $clog2(SCREEN_HEIGHT) : 1;
  localparam logic [X_W-1:0] X_LAST = X_W'(SCREEN_WIDTH - 1);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(SCREEN_HEIGHT - 1);

  sched_state_e   state_q, state_d;
  logic [X_W-1:0] x_q, x_d, sx_q, sx_d;
  logic [Y_W-1:0] y_q, y_d, sy_q, sy_d;
  logic           aborted_q, aborted_d;
  logic           valid_q, valid_d;
  logic           sof_q, sof_d, eol_q, eol_d, eof_q, eof_d;
  logic           busy_q, busy_d, done_q, done_d;
  logic           cerr_q, cerr_d;

  logic           issue, first_px, line_end, last_px;
  logic           cnt_full, cnt_empty, cnt_underflow;

  ray_credit_counter #(.MAX(MAX_INFLIGHT)) u_credit (
    .clk       (clk),
    .rst       (rst),
    .inc       (issue),
    .dec       (ray_retire),
    .count     (inflight),
    .full      (cnt_full),
    .empty     (cnt_empty),
    .underflow (cnt_underflow)
  );

  assign first_px = (x_q == '0) && (y_q == '0);
  assign line_end = (x_q == X_LAST);
  assign last_px  = line_end && (y_q == Y_LAST);

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    aborted_d = aborted_q;
    issue     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = RUN;
          x_d       = '0;
          y_d       = '0;
          aborted_d = 1'b0;
        end
      end
      RUN: begin
        if (abort) begin
          state_d   = DRAIN;
          aborted_d = 1'b1;
        // A retire in the same cycle frees the credit this issue consumes.
        end else if (!cnt_full || ray_retire) begin
          issue = 1'b1;
          if (line_end) begin
            x_d = '0;
            y_d = (y_q == Y_LAST) ? '0 : y_q + Y_W'(1);
          end else begin
            x_d = x_q + X_W'(1);
          end
          if (last_px) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (cnt_empty) state_d = aborted_q ? IDLE : DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    valid_d = issue;
    sx_d    = issue ? x_q : sx_q;
    sy_d    = issue ? y_q : sy_q;
    sof_d   = issue && first_px;
    eol_d   = issue && line_end;
    eof_d   = issue && last_px;
    busy_d  = (state_d != IDLE);
    done_d  = (state_d == DONE);
    cerr_d  = cerr_q || cnt_underflow;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      x_q       <= '0;
      y_q       <= '0;
      aborted_q <= 1'b0;
      sx_q      <= '0;
      sy_q      <= '0;
      valid_q   <= 1'b0;
      sof_q     <= 1'b0;
      eol_q     <= 1'b0;
      eof_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      cerr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      aborted_q <= aborted_d;
      sx_q      <= sx_d;
      sy_q      <= sy_d;
      valid_q   <= valid_d;
      sof_q     <= sof_d;
      eol_q     <= eol_d;
      eof_q     <= eof_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      cerr_q    <= cerr_d;
    end
  end

  // Integer pixel coordinates; ray_generator applies the fractional shift.
  assign screen_x     = fp'(32'(sx_q));
  assign screen_y     = fp'(32'(sy_q));
  assign coords_valid = valid_q;
  assign sof          = sof_q;
  assign eol          = eol_q;
  assign eof          = eof_q;
  assign busy         = busy_q;
  assign frame_done   = done_q;
  assign credit_err   = cerr_q;

endmodule
